// File: rtl/bus_node_fifo.sv
// Per-device bus node: a TX queue from the device driver to the bus and an RX queue
// from the bus to the device monitor, with sticky error flags for overflow, misuse and misrouting.
module bus_node_fifo #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       tx_full,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rd_en,
  output logic                       rx_valid,
  output logic [pckg_sz-1:0]         rd_data,
  output logic                       rx_full,
  output logic                       tx_ovf,
  output logic                       rx_ovf,
  output logic                       pop_err,
  output logic                       misroute
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [AW-1:0]      tx_wr_ptr, tx_rd_ptr;
  logic [AW-1:0]      rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0]      rx_count;

  logic tx_wr_ok, tx_pop_ok, rx_wr_ok, rx_rd_ok;
  logic [7:0] push_dest;

  // Status and show-ahead heads depend only on registered state.
  assign tx_full  = (tx_count == CW'(depth));
  assign pndng    = (tx_count != '0);
  assign D_pop    = pndng ? tx_mem[tx_rd_ptr] : '0;
  assign rx_full  = (rx_count == CW'(depth));
  assign rx_valid = (rx_count != '0);
  assign rd_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;

  // A write into a full queue is still taken when the head leaves in the same cycle.
  assign tx_wr_ok  = wr_en && (!tx_full || pop);
  assign tx_pop_ok = pop && pndng;
  assign rx_wr_ok  = push && (!rx_full || rd_en);
  assign rx_rd_ok  = rd_en && rx_valid;
  assign push_dest = D_push[pckg_sz-1 -: 8];

  always_ff @(posedge clk) begin
    if (!reset && tx_wr_ok) tx_mem[tx_wr_ptr] <= wr_data;
    if (!reset && rx_wr_ok) rx_mem[rx_wr_ptr] <= D_push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      pop_err   <= 1'b0;
      misroute  <= 1'b0;
    end else begin
      if (tx_wr_ok)  tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop_ok) tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_wr_ok, tx_pop_ok})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase

      if (rx_wr_ok) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_rd_ok) rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_wr_ok, rx_rd_ok})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase

      if (wr_en && !tx_wr_ok) tx_ovf <= 1'b1;
      if (push && !rx_wr_ok)  rx_ovf <= 1'b1;
      if (pop && !pndng)      pop_err <= 1'b1;
      // Destination is checked on every push, even one that gets dropped.
      if (push && push_dest != id && push_dest != broadcast) misroute <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_node_fifo.sv
// Directed bench for bus_node_fifo (id=2): TX/RX ordering, full/overflow, wrap,
// misroute detection, empty misuse and mid-operation reset.
module tb_bus_node_fifo;

  localparam int PW = 16;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [PW-1:0] wr_data;
  logic          tx_full;
  logic [3:0]    tx_count;
  logic          pndng;
  logic [PW-1:0] D_pop;
  logic          pop;
  logic          push;
  logic [PW-1:0] D_push;
  logic          rd_en;
  logic          rx_valid;
  logic [PW-1:0] rd_data;
  logic          rx_full;
  logic          tx_ovf;
  logic          rx_ovf;
  logic          pop_err;
  logic          misroute;

  int checks   = 0;
  int failures = 0;

  bus_node_fifo #(
    .pckg_sz(PW),
    .depth(8),
    .id(8'd2),
    .broadcast(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .tx_full(tx_full),
    .tx_count(tx_count),
    .pndng(pndng),
    .D_pop(D_pop),
    .pop(pop),
    .push(push),
    .D_push(D_push),
    .rd_en(rd_en),
    .rx_valid(rx_valid),
    .rd_data(rd_data),
    .rx_full(rx_full),
    .tx_ovf(tx_ovf),
    .rx_ovf(rx_ovf),
    .pop_err(pop_err),
    .misroute(misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge take them, then return inputs to idle 1ns later.
  task automatic applyStimulus(input logic w, input logic [PW-1:0] wd, input logic p,
                               input logic ps, input logic [PW-1:0] pd, input logic r,
                               input logic rst);
    reset   = rst;
    wr_en   = w;
    wr_data = wd;
    pop     = p;
    push    = ps;
    D_push  = pd;
    rd_en   = r;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    pop     = 1'b0;
    push    = 1'b0;
    D_push  = '0;
    rd_en   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; pop = 1'b0;
    push = 1'b0; D_push = '0; rd_en = 1'b0;
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 0, 1);
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 0, 1);

    // Reset state
    checkOutput("rst_tx_count", 32'(tx_count), 32'd0);
    checkOutput("rst_pndng", 32'(pndng), 32'd0);
    checkOutput("rst_D_pop", 32'(D_pop), 32'h0);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
    checkOutput("rst_full", 32'({tx_full, rx_full}), 32'd0);
    checkOutput("rst_flags", 32'({tx_ovf, rx_ovf, pop_err, misroute}), 32'd0);

    // Three writes then three back-to-back pops
    applyStimulus(1, 16'h0155, 0, 0, 16'h0, 0, 0);
    checkOutput("wr1_pndng", 32'(pndng), 32'd1);
    checkOutput("wr1_D_pop", 32'(D_pop), 32'h0155);
    applyStimulus(1, 16'h02AA, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 16'hFF01, 0, 0, 16'h0, 0, 0);
    checkOutput("wr3_tx_count", 32'(tx_count), 32'd3);
    checkOutput("pop1_D_pop", 32'(D_pop), 32'h0155);
    applyStimulus(0, 16'h0, 1, 0, 16'h0, 0, 0);
    checkOutput("pop2_D_pop", 32'(D_pop), 32'h02AA);
    applyStimulus(0, 16'h0, 1, 0, 16'h0, 0, 0);
    checkOutput("pop3_D_pop", 32'(D_pop), 32'hFF01);
    applyStimulus(0, 16'h0, 1, 0, 16'h0, 0, 0);
    checkOutput("drain_pndng", 32'(pndng), 32'd0);
    checkOutput("drain_D_pop", 32'(D_pop), 32'h0);
    checkOutput("drain_pop_err", 32'(pop_err), 32'd0);

    // Fill TX, overflow alone, then a write accepted alongside a pop
    for (int i = 0; i < 8; i++) applyStimulus(1, 16'h1000 + 16'(i), 0, 0, 16'h0, 0, 0);
    checkOutput("fill_tx_full", 32'(tx_full), 32'd1);
    checkOutput("fill_tx_count", 32'(tx_count), 32'd8);
    checkOutput("fill_tx_ovf_clear", 32'(tx_ovf), 32'd0);
    applyStimulus(1, 16'hDEAD, 0, 0, 16'h0, 0, 0);
    checkOutput("ovf_tx_ovf", 32'(tx_ovf), 32'd1);
    checkOutput("ovf_tx_count", 32'(tx_count), 32'd8);
    checkOutput("ovf_D_pop", 32'(D_pop), 32'h1000);
    applyStimulus(1, 16'hBEEF, 1, 0, 16'h0, 0, 0);
    checkOutput("full_wrpop_count", 32'(tx_count), 32'd8);
    for (int i = 1; i < 8; i++) begin
      checkOutput("full_order", 32'(D_pop), 32'h1000 + 32'(i));
      applyStimulus(0, 16'h0, 1, 0, 16'h0, 0, 0);
    end
    checkOutput("full_last", 32'(D_pop), 32'hBEEF);
    applyStimulus(0, 16'h0, 1, 0, 16'h0, 0, 0);
    checkOutput("full_empty", 32'(pndng), 32'd0);

    // Streaming write+pop across the pointer wrap
    applyStimulus(1, 16'h2000, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      checkOutput("wrap_D_pop", 32'(D_pop), 32'h2000 + 32'(i));
      applyStimulus(1, 16'h2001 + 16'(i), 1, 0, 16'h0, 0, 0);
      checkOutput("wrap_count", 32'(tx_count), 32'd1);
    end
    checkOutput("wrap_tail", 32'(D_pop), 32'h2014);
    applyStimulus(0, 16'h0, 1, 0, 16'h0, 0, 0);
    checkOutput("wrap_empty", 32'(tx_count), 32'd0);

    // Misroute detection at id=2
    applyStimulus(0, 16'h0, 0, 1, 16'h0233, 0, 0);
    checkOutput("rx1_valid", 32'(rx_valid), 32'd1);
    checkOutput("rx1_misroute", 32'(misroute), 32'd0);
    applyStimulus(0, 16'h0, 0, 1, 16'hFF44, 0, 0);
    checkOutput("rx2_misroute", 32'(misroute), 32'd0);
    applyStimulus(0, 16'h0, 0, 1, 16'h0355, 0, 0);
    checkOutput("rx3_misroute", 32'(misroute), 32'd1);
    checkOutput("rx_read1", 32'(rd_data), 32'h0233);
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 1, 0);
    checkOutput("rx_read2", 32'(rd_data), 32'hFF44);
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 1, 0);
    checkOutput("rx_read3", 32'(rd_data), 32'h0355);
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 1, 0);
    checkOutput("rx_drained", 32'({rx_valid, rd_data}), 32'h0);

    // Empty-queue misuse
    applyStimulus(0, 16'h0, 1, 0, 16'h0, 0, 0);
    checkOutput("pop_empty_err", 32'(pop_err), 32'd1);
    checkOutput("pop_empty_count", 32'(tx_count), 32'd0);
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 1, 0);
    checkOutput("rd_empty_rx_ovf", 32'(rx_ovf), 32'd0);
    checkOutput("rd_empty_valid", 32'(rx_valid), 32'd0);
    applyStimulus(1, 16'h5A5A, 1, 0, 16'h0, 0, 0);
    checkOutput("pop_empty_wr_count", 32'(tx_count), 32'd1);
    checkOutput("pop_empty_wr_data", 32'(D_pop), 32'h5A5A);
    applyStimulus(0, 16'h0, 1, 0, 16'h0, 0, 0);

    // RX full and overflow
    for (int i = 0; i < 8; i++) applyStimulus(0, 16'h0, 0, 1, 16'h0210 + 16'(i), 0, 0);
    checkOutput("rx_full", 32'(rx_full), 32'd1);
    applyStimulus(0, 16'h0, 0, 1, 16'h0299, 0, 0);
    checkOutput("rx_ovf_set", 32'(rx_ovf), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("rx_full_order", 32'(rd_data), 32'h0210 + 32'(i));
      applyStimulus(0, 16'h0, 0, 0, 16'h0, 1, 0);
    end
    checkOutput("rx_full_drained", 32'(rx_valid), 32'd0);

    // Reset with queued data and concurrent traffic
    for (int i = 0; i < 5; i++) applyStimulus(1, 16'h3000 + 16'(i), 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 16'h0, 0, 1, 16'h0240 + 16'(i), 0, 0);
    checkOutput("pre_rst_tx_count", 32'(tx_count), 32'd5);
    checkOutput("pre_rst_rd_data", 32'(rd_data), 32'h0240);
    applyStimulus(1, 16'h7777, 1, 1, 16'h0277, 0, 1);
    checkOutput("mid_rst_tx_count", 32'(tx_count), 32'd0);
    checkOutput("mid_rst_heads", 32'({pndng, rx_valid, D_pop, rd_data}), 32'h0);
    checkOutput("mid_rst_flags", 32'({tx_ovf, rx_ovf, pop_err, misroute}), 32'd0);
    applyStimulus(1, 16'h4444, 0, 0, 16'h0, 0, 0);
    checkOutput("post_rst_count", 32'(tx_count), 32'd1);
    checkOutput("post_rst_D_pop", 32'(D_pop), 32'h4444);
    checkOutput("post_rst_rx_valid", 32'(rx_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_node_fifo.md
# bus_node_fifo

Per-device FIFO node sitting directly beside the bus generator/arbiter, one instance per device port. Its TX queue buffers packets written by the device-side driver and presents them to the bus via `pndng`/`D_pop`, dequeuing on the bus's `pop`. Its RX queue captures packets the bus delivers with `push`/`D_push` and holds them for the device-side monitor. Packets are `pckg_sz` bits; the top 8 bits are the destination ID.

## Interface
Parameters:
- `pckg_sz`, 16, packet width in bits; must be ≥ 9.
- `depth`, 8, entries per queue; a power of two ≥ 2.
- `id`, 0, this node's 8-bit device ID.
- `broadcast`, 8'hFF, broadcast destination ID.

Ports (clock and reset first):
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `reset`, in, 1, synchronous, active-high.
- `wr_en`, in, 1, driver enqueue request into TX.
- `wr_data`, in, `pckg_sz`, TX packet.
- `tx_full`, out, 1, TX holds `depth` entries.
- `tx_count`, out, `$clog2(depth+1)`, TX occupancy.
- `pndng`, out, 1, TX not empty (to bus).
- `D_pop`, out, `pckg_sz`, TX head (show-ahead); 0 when empty.
- `pop`, in, 1, bus dequeues TX head.
- `push`, in, 1, bus delivers a packet.
- `D_push`, in, `pckg_sz`, delivered packet.
- `rd_en`, in, 1, monitor dequeues RX head.
- `rx_valid`, out, 1, RX not empty.
- `rd_data`, out, `pckg_sz`, RX head (show-ahead); 0 when empty.
- `rx_full`, out, 1, RX holds `depth` entries.
- `tx_ovf`, out, 1, sticky: a TX write was dropped.
- `rx_ovf`, out, 1, sticky: an RX push was dropped.
- `pop_err`, out, 1, sticky: `pop` was asserted while TX was empty.
- `misroute`, out, 1, sticky: a packet was received whose dest ≠ `id` and ≠ `broadcast`.

## Operation
- Each queue is a circular buffer with read/write pointers of `$clog2(depth)` bits that wrap naturally, plus a count register of `$clog2(depth+1)` bits. Full means count == `depth`; empty means count == 0.
- TX write is accepted when `wr_en` && (!`tx_full` || `pop`).
- Write to a full TX with no `pop` in the same cycle: data is dropped, state is unchanged, and `tx_ovf` is set.
- TX pop is accepted when `pop` && `pndng`.
- `pop` while TX is empty: ignored and `pop_err` is set. With simultaneous `wr_en`, the write is still accepted.
- Simultaneous accepted write and pop: count is unchanged and both pointers advance.
- The RX side mirrors TX: `push` plays the write role and `rd_en` the pop role.
  - A dropped push sets `rx_ovf`.
  - `rd_en` while RX is empty is ignored silently.
- Misroute check on every push, including dropped ones: if `D_push[pckg_sz-1 -: 8]` ≠ `id` and ≠ `broadcast`, set `misroute`. The packet is still stored if space allows.
- Sticky flags clear only on `reset`.
- Reset values:
  - Pointers and counts are 0.
  - `pndng`, `rx_valid`, `tx_full`, `rx_full`, `tx_count`, all flags, `D_pop` and `rd_data` are 0.
  - Storage arrays are not reset.
- `reset` asserted mid-operation discards all queued packets at that edge and ignores all other inputs in that cycle.

## Timing
- Write-to-visible latency is 1 cycle: `wr_en` sampled at edge N gives `pndng`=1 and `D_pop`=data after edge N. The same applies to `push` → `rx_valid`/`rd_data`.
- `D_pop`, `rd_data`, `pndng`, `rx_valid`, the full flags and the counts are combinational from registered state only. There is no input-to-output combinational path.
- After a pop at edge N, `D_pop` shows the next entry (or 0 if empty) immediately after edge N.
- Bus handshake: the bus may assert `pop` in any cycle in which `pndng` is 1 and reads `D_pop` in that same cycle. Back-to-back pops every cycle are supported.
- Pointer wrap from `depth-1` to 0 introduces no bubble.

## Test plan
- Reset, then write 16'h0155, 16'h02AA, 16'hFF01 on consecutive cycles. `pndng` rises 1 cycle after the first write and `tx_count`=3. Three pops on consecutive cycles read `D_pop` = 0155, 02AA, FF01, after which `pndng`=0 and `D_pop`=0.
- Fill TX with 8 packets → `tx_full`=1. A 9th write alone is dropped and sets `tx_ovf`. A 9th write together with `pop` is accepted: count stays 8 and order is preserved.
- Run 20 write/pop cycles at depth 8 with simultaneous write+pop, crossing the wrap point. The output sequence must equal the input sequence with no bubble.
- With `id`=2: push 16'h0233 → `misroute`=0. Push 16'hFF44 → `misroute`=0. Push 16'h0355 → `misroute`=1 and the packet is stored. `rd_data` sequence is 0233, FF44, 0355.
- `pop` on empty TX → `pop_err`=1 and counts unchanged. `rd_en` on empty RX → no flag.
- Load 5 TX and 3 RX entries, then assert `reset` for one cycle together with `wr_en`, `push` and `pop`. Afterwards all counts, flags, `D_pop` and `rd_data` are 0, and the next write appears alone.
